// File: rtl/riscv_pkg.sv
// Shared RV32I constants and types for the memory stage.
// The funct3 encodings select access size and load sign; the enum names the handshake FSM states.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data memory port.
// Builds the store byte enables and store data, extracts and extends load data, and flags misalignment.
module dmem_lane_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] shifted;

  always_comb begin
    shifted    = rdata >> {addr[1:0], 3'b000};
    wdata      = store_data;
    be         = 4'b1111;
    misaligned = 1'b0;
    // funct3[1:0] is the access size; 11 (and so 011/111) behaves as a word
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr[1:0];
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be         = addr[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        misaligned = addr[0];
      end
      default: begin
        misaligned = |addr[1:0];
      end
    endcase
  end

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// RV32I M stage: issues data-memory requests, stalls while memory is busy, and holds the M/W register.
// Handshake: dmem_req stays high, with all request fields stable, until a cycle where dmem_ready is high; that cycle completes the access.
module memory_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_m,
  input  logic [31:0] execute_out_m,
  input  logic [31:0] store_data_m,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [2:0]  funct3_m,
  input  logic [4:0]  reg_write_addr_m,
  input  logic        reg_write_en_m,
  input  logic        reg_writedata_sel_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_m,
  output logic        misalign_w,
  output logic [31:0] dmem_readdata_w,
  output logic [31:0] execute_out_w,
  output logic [4:0]  reg_write_addr_w,
  output logic        reg_write_en_w,
  output logic        reg_writedata_sel_w,
  output mem_state_t  state
);

  mem_state_t  state_next;
  logic [31:0] load_data;
  logic        align_bad;
  logic        is_access;
  logic        misaligned;
  logic        mem_op;

  dmem_lane_align u_align (
    .funct3     (funct3_m),
    .addr       (execute_out_m),
    .store_data (store_data_m),
    .rdata      (dmem_rdata),
    .wdata      (dmem_wdata),
    .be         (dmem_be),
    .load_data  (load_data),
    .misaligned (align_bad)
  );

  // Alignment only matters for real memory ops; an ALU result is just a number.
  assign is_access  = valid_m & (mem_read_m | mem_write_m);
  assign misaligned = is_access & align_bad;
  assign mem_op     = is_access & ~align_bad;
  assign dmem_addr  = {execute_out_m[31:2], 2'b00};
  assign dmem_we    = mem_write_m;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_op && !dmem_ready) state_next = WAIT;
      WAIT:    if (dmem_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Upstream holds the _m inputs during a stall, so the request is the same in both states.
  always_comb begin
    dmem_req = mem_op;
    stall_m  = mem_op & ~dmem_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_w          <= 1'b0;
      dmem_readdata_w     <= 32'h0;
      execute_out_w       <= 32'h0;
      reg_write_addr_w    <= 5'h0;
      reg_write_en_w      <= 1'b0;
      reg_writedata_sel_w <= 1'b0;
    end else if (stall_m) begin
      reg_write_en_w <= 1'b0;
      misalign_w     <= 1'b0;
    end else begin
      misalign_w          <= misaligned;
      dmem_readdata_w     <= load_data;
      execute_out_w       <= execute_out_m;
      reg_write_addr_w    <= reg_write_addr_m;
      reg_write_en_w      <= valid_m & reg_write_en_m & ~misaligned;
      reg_writedata_sel_w <= reg_writedata_sel_m;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: drives the M-stage inputs and the memory response by hand.
// Expected values are hand-computed from the RV32I load/store lane rules.
module tb_memory_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_m;
  logic [31:0] execute_out_m;
  logic [31:0] store_data_m;
  logic        mem_read_m;
  logic        mem_write_m;
  logic [2:0]  funct3_m;
  logic [4:0]  reg_write_addr_m;
  logic        reg_write_en_m;
  logic        reg_writedata_sel_m;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall_m;
  logic        misalign_w;
  logic [31:0] dmem_readdata_w;
  logic [31:0] execute_out_w;
  logic [4:0]  reg_write_addr_w;
  logic        reg_write_en_w;
  logic        reg_writedata_sel_w;
  mem_state_t  state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .valid_m             (valid_m),
    .execute_out_m       (execute_out_m),
    .store_data_m        (store_data_m),
    .mem_read_m          (mem_read_m),
    .mem_write_m         (mem_write_m),
    .funct3_m            (funct3_m),
    .reg_write_addr_m    (reg_write_addr_m),
    .reg_write_en_m      (reg_write_en_m),
    .reg_writedata_sel_m (reg_writedata_sel_m),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_be             (dmem_be),
    .dmem_ready          (dmem_ready),
    .dmem_rdata          (dmem_rdata),
    .stall_m             (stall_m),
    .misalign_w          (misalign_w),
    .dmem_readdata_w     (dmem_readdata_w),
    .execute_out_w       (execute_out_w),
    .reg_write_addr_w    (reg_write_addr_w),
    .reg_write_en_w      (reg_write_en_w),
    .reg_writedata_sel_w (reg_writedata_sel_w),
    .state               (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd_addr,
                       input logic we_reg, input logic sel);
    valid_m             = v;
    mem_read_m          = rd;
    mem_write_m         = wr;
    funct3_m            = f3;
    execute_out_m       = addr;
    store_data_m        = sd;
    reg_write_addr_m    = rd_addr;
    reg_write_en_m      = we_reg;
    reg_writedata_sel_m = sel;
  endtask

  task automatic check_w_cleared(input string tag);
    check({tag, "_en_w"},   32'(reg_write_en_w), 32'h0);
    check({tag, "_mis_w"},  32'(misalign_w), 32'h0);
    check({tag, "_rd_w"},   dmem_readdata_w, 32'h0);
    check({tag, "_ex_w"},   execute_out_w, 32'h0);
    check({tag, "_addr_w"}, 32'(reg_write_addr_w), 32'h0);
    check({tag, "_sel_w"},  32'(reg_writedata_sel_w), 32'h0);
  endtask

  initial begin
    rst        = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    step();
    step();
    check("rst_state", 32'(state), 32'(IDLE));
    check("rst_stall", 32'(stall_m), 32'h0);
    check("rst_req", 32'(dmem_req), 32'h0);
    check_w_cleared("rst");
    rst = 1'b0;
    step();

    // LW 0x100, zero-wait
    drive(1'b1, 1'b1, 1'b0, F3_W, 32'h100, 32'h0, 5'd5, 1'b1, 1'b0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    #1;
    check("lw_req", 32'(dmem_req), 32'h1);
    check("lw_we", 32'(dmem_we), 32'h0);
    check("lw_addr", dmem_addr, 32'h100);
    check("lw_stall", 32'(stall_m), 32'h0);
    step();
    check("lw_rd_w", dmem_readdata_w, 32'hDEADBEEF);
    check("lw_en_w", 32'(reg_write_en_w), 32'h1);
    check("lw_addr_w", 32'(reg_write_addr_w), 32'd5);
    check("lw_sel_w", 32'(reg_writedata_sel_w), 32'h0);
    check("lw_state", 32'(state), 32'(IDLE));

    // LB 0x103, two wait cycles, presented right after the previous ready
    drive(1'b1, 1'b1, 1'b0, F3_B, 32'h103, 32'h0, 5'd6, 1'b1, 1'b0);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h80FF0000;
    #1;
    check("lb_req", 32'(dmem_req), 32'h1);
    check("lb_addr", dmem_addr, 32'h100);
    check("lb_stall1", 32'(stall_m), 32'h1);
    step();
    check("lb_state_wait", 32'(state), 32'(WAIT));
    check("lb_bubble1", 32'(reg_write_en_w), 32'h0);
    check("lb_stall2", 32'(stall_m), 32'h1);
    step();
    check("lb_bubble2", 32'(reg_write_en_w), 32'h0);
    dmem_ready = 1'b1;
    #1;
    check("lb_stall_rel", 32'(stall_m), 32'h0);
    check("lb_req_hold", 32'(dmem_req), 32'h1);
    step();
    check("lb_rd_w", dmem_readdata_w, 32'hFFFFFF80);
    check("lb_en_w", 32'(reg_write_en_w), 32'h1);
    check("lb_addr_w", 32'(reg_write_addr_w), 32'd6);
    check("lb_state_idle", 32'(state), 32'(IDLE));

    // SH 0x202
    drive(1'b1, 1'b0, 1'b1, F3_H, 32'h202, 32'h00001234, 5'd0, 1'b0, 1'b0);
    #1;
    check("sh_req", 32'(dmem_req), 32'h1);
    check("sh_we", 32'(dmem_we), 32'h1);
    check("sh_addr", dmem_addr, 32'h200);
    check("sh_be", 32'(dmem_be), 32'hC);
    check("sh_wdata", dmem_wdata, 32'h12341234);
    step();
    check("sh_en_w", 32'(reg_write_en_w), 32'h0);

    // SB 0x101 and SW 0x10C
    drive(1'b1, 1'b0, 1'b1, F3_B, 32'h101, 32'h000000AB, 5'd0, 1'b0, 1'b0);
    #1;
    check("sb_be", 32'(dmem_be), 32'h2);
    check("sb_wdata", dmem_wdata, 32'hABABABAB);
    check("sb_addr", dmem_addr, 32'h100);
    step();
    drive(1'b1, 1'b0, 1'b1, F3_W, 32'h10C, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0);
    #1;
    check("sw_be", 32'(dmem_be), 32'hF);
    check("sw_wdata", dmem_wdata, 32'hCAFEF00D);
    step();

    // LW 0x101 misaligned: no request, no stall even with memory not ready
    drive(1'b1, 1'b1, 1'b0, F3_W, 32'h101, 32'h0, 5'd9, 1'b1, 1'b0);
    dmem_ready = 1'b0;
    #1;
    check("mis_req", 32'(dmem_req), 32'h0);
    check("mis_stall", 32'(stall_m), 32'h0);
    step();
    check("mis_w", 32'(misalign_w), 32'h1);
    check("mis_en_w", 32'(reg_write_en_w), 32'h0);
    check("mis_state", 32'(state), 32'(IDLE));

    // SH 0x203 misaligned store
    drive(1'b1, 1'b0, 1'b1, F3_H, 32'h203, 32'h1234, 5'd0, 1'b0, 1'b0);
    #1;
    check("shmis_req", 32'(dmem_req), 32'h0);
    step();
    check("shmis_w", 32'(misalign_w), 32'h1);

    // LW 0x104 stuck in WAIT, then reset
    drive(1'b1, 1'b1, 1'b0, F3_W, 32'h104, 32'h0, 5'd3, 1'b1, 1'b0);
    dmem_rdata = 32'h11112222;
    step();
    check("rw_state_wait", 32'(state), 32'(WAIT));
    check("rw_stall", 32'(stall_m), 32'h1);
    rst = 1'b1;
    step();
    check("rw_state_idle", 32'(state), 32'(IDLE));
    check_w_cleared("rw");
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, F3_W, 32'h5, 32'h0, 5'd7, 1'b1, 1'b1);
    #1;
    check("add_req", 32'(dmem_req), 32'h0);
    check("add_stall", 32'(stall_m), 32'h0);
    step();
    check("add_sel_w", 32'(reg_writedata_sel_w), 32'h1);
    check("add_ex_w", execute_out_w, 32'h5);
    check("add_en_w", 32'(reg_write_en_w), 32'h1);
    check("add_addr_w", 32'(reg_write_addr_w), 32'd7);
    check("add_mis_w", 32'(misalign_w), 32'h0);

    // LHU 0x006 and LH 0x002
    drive(1'b1, 1'b1, 1'b0, F3_HU, 32'h006, 32'h0, 5'd8, 1'b1, 1'b0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hBEEF0000;
    #1;
    check("lhu_addr", dmem_addr, 32'h4);
    step();
    check("lhu_rd_w", dmem_readdata_w, 32'h0000BEEF);
    drive(1'b1, 1'b1, 1'b0, F3_H, 32'h002, 32'h0, 5'd8, 1'b1, 1'b0);
    dmem_rdata = 32'h80010000;
    step();
    check("lh_rd_w", dmem_readdata_w, 32'hFFFF8001);

    // LBU 0x001 and funct3 011 treated as LW
    drive(1'b1, 1'b1, 1'b0, F3_BU, 32'h001, 32'h0, 5'd8, 1'b1, 1'b0);
    dmem_rdata = 32'h000080FF;
    step();
    check("lbu_rd_w", dmem_readdata_w, 32'h00000080);
    drive(1'b1, 1'b1, 1'b0, 3'b011, 32'h008, 32'h0, 5'd8, 1'b1, 1'b0);
    dmem_rdata = 32'h89ABCDEF;
    step();
    check("f3_011_rd_w", dmem_readdata_w, 32'h89ABCDEF);

    // Invalid slot: no request even with mem_read set
    drive(1'b0, 1'b1, 1'b0, F3_W, 32'h100, 32'h0, 5'd8, 1'b1, 1'b0);
    #1;
    check("inv_req", 32'(dmem_req), 32'h0);
    step();
    check("inv_en_w", 32'(reg_write_en_w), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
